// File: rtl/fib_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one binary-to-Fibonacci converter among NREQ requesters.
// Latency: gnt one cycle after req in IDLE; done/fib_out one cycle after cv_done (or TIMEOUT cycles after gnt).
// Backpressure: requests wait while busy (RUN/CLEAR); a held req is never lost and re-competes round-robin.
module fib_conv_arbiter #(
  parameter int NREQ    = 4,
  parameter int BIN_W   = 16,
  parameter int FIB_W   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BIN_W-1:0] bin_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [FIB_W-1:0]      fib_out,
  output logic                  err,
  output logic                  busy,
  output logic                  cv_begin,
  output logic [BIN_W-1:0]      cv_bin,
  input  logic                  cv_done,
  input  logic [FIB_W-1:0]      cv_fib
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;      // last winner; also the owner of the conversion in flight
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    nxt;
  logic             any;
  logic [BIN_W-1:0] sel_bin;

  // Round-robin pick: first requester found scanning ptr+1, ptr+2, ... modulo NREQ
  always_comb begin
    int idx;
    idx = 0;
    nxt = ptr;
    any = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any && req[idx[PW-1:0]]) begin
        any = 1'b1;
        nxt = idx[PW-1:0];
      end
    end
  end

  // Operand of the requester that would win this cycle
  always_comb begin
    sel_bin = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (nxt == PW'(i)) sel_bin = bin_in[i*BIN_W +: BIN_W];
    end
  end

  // Sequencer: grant, run converter until done or timeout, then wait for converter done to drop
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PW'(NREQ - 1);
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      fib_out  <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      cv_begin <= 1'b0;
      cv_bin   <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            gnt      <= NREQ'(1) << nxt;
            cv_bin   <= sel_bin;
            cv_begin <= 1'b1;
            ptr      <= nxt;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          // A converter completion in the timeout cycle still counts as a success
          if (cv_done) begin
            fib_out  <= cv_fib;
            done     <= NREQ'(1) << ptr;
            cv_begin <= 1'b0;
            state    <= CLEAR;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            fib_out  <= '0;
            done     <= NREQ'(1) << ptr;
            err      <= 1'b1;
            cv_begin <= 1'b0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          // Hold off the next start until the converter has dropped its done flag
          if (!cv_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          cv_begin <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
